// File: rtl/fram_pkg.sv
// Shared definitions for the FRAM bank arbiter: default parameters, the response
// pipeline stage type and the address-to-bank split helpers.
package fram_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_INTERLEAVE = 0;
  localparam int DEF_STARVE_MAX = 3;
  localparam int DEF_BANK_W     = $clog2(DEF_NUM_BANKS);

  typedef struct packed {
    logic                  valid;
    logic [DEF_BANK_W-1:0] bank;
  } rsp_stage_t;

  // Bank index: MSBs for a linear layout, LSBs when consecutive words interleave.
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int addr_w,
                                          input int bank_w, input bit interleave);
    logic [31:0] mask;
    mask = (32'd1 << bank_w) - 32'd1;
    if (interleave)
      return addr & mask;
    else
      return (addr >> (addr_w - bank_w)) & mask;
  endfunction

  function automatic logic [31:0] bank_addr_of(input logic [31:0] addr, input int addr_w,
                                               input int bank_w, input bit interleave);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w - bank_w)) - 32'd1;
    if (interleave)
      return addr >> bank_w;
    else
      return addr & mask;
  endfunction

endpackage

// File: rtl/fram_rsp_pipe.sv
// Fixed-depth shift register carrying {valid, bank} alongside the BRAM read latency.
module fram_rsp_pipe
  import fram_pkg::*;
#(
  parameter int  DEPTH   = DEF_RD_LAT,
  parameter type stage_t = rsp_stage_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/fram_bank_arbiter.sv
// Registered read/write arbiter onto NUM_BANKS single-port BRAM banks, with a
// starvation guard for the read port and a saturating conflict counter.
module fram_bank_arbiter
  import fram_pkg::*;
#(
  parameter int  NUM_BANKS  = DEF_NUM_BANKS,
  parameter int  ADDR_W     = DEF_ADDR_W,
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  RD_LAT     = DEF_RD_LAT,
  parameter int  INTERLEAVE = DEF_INTERLEAVE,
  parameter int  STARVE_MAX = DEF_STARVE_MAX,
  localparam int BANK_AW    = ADDR_W - $clog2(NUM_BANKS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rd_valid,
  output logic                               rd_ready,
  input  logic [ADDR_W-1:0]                  rd_addr,
  output logic                               rsp_valid,
  output logic [DATA_W-1:0]                  rsp_data,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [NUM_BANKS-1:0][BANK_AW-1:0]  bram_addr,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]   bram_wdata,
  output logic [NUM_BANKS-1:0]               bram_we,
  output logic [NUM_BANKS-1:0]               bram_en,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]   bram_rdata,
  output logic [15:0]                        conflict_cnt
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int SC_W   = $clog2(STARVE_MAX + 1);
  localparam bit ILV    = (INTERLEAVE != 0);

  typedef struct packed {
    logic              valid;
    logic [BANK_W-1:0] bank;
  } stage_t;

  logic [BANK_W-1:0]  rd_bank, wr_bank;
  logic [BANK_AW-1:0] rd_baddr, wr_baddr;
  logic               conflict, force_rd, rd_gnt, wr_gnt;
  logic [SC_W-1:0]    starve_cnt_reg;
  logic [15:0]        conflict_cnt_reg;
  stage_t             rsp_in, rsp_out;

  assign rd_bank  = BANK_W'(bank_of(32'(rd_addr), ADDR_W, BANK_W, ILV));
  assign wr_bank  = BANK_W'(bank_of(32'(wr_addr), ADDR_W, BANK_W, ILV));
  assign rd_baddr = BANK_AW'(bank_addr_of(32'(rd_addr), ADDR_W, BANK_W, ILV));
  assign wr_baddr = BANK_AW'(bank_addr_of(32'(wr_addr), ADDR_W, BANK_W, ILV));

  // Writes win same-bank conflicts until the read has lost STARVE_MAX times in a row.
  assign conflict = rd_valid && wr_valid && (rd_bank == wr_bank);
  assign force_rd = (starve_cnt_reg == SC_W'(STARVE_MAX));
  assign rd_gnt   = rst_n && rd_valid && (!conflict || force_rd);
  assign wr_gnt   = rst_n && wr_valid && (!conflict || !force_rd);
  assign rd_ready = rd_gnt;
  assign wr_ready = wr_gnt;

  genvar gi;
  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic rd_hit, wr_hit;
    assign rd_hit          = rd_gnt && (rd_bank == BANK_W'(gi));
    assign wr_hit          = wr_gnt && (wr_bank == BANK_W'(gi));
    assign bram_en[gi]     = rd_hit || wr_hit;
    assign bram_we[gi]     = wr_hit;
    assign bram_addr[gi]   = wr_hit ? wr_baddr : (rd_hit ? rd_baddr : '0);
    assign bram_wdata[gi]  = wr_hit ? wr_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      if (!rd_valid || rd_gnt)
        starve_cnt_reg <= '0;
      else if (conflict)
        starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
      if (conflict && (conflict_cnt_reg != 16'hFFFF))
        conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

  assign rsp_in.valid = rd_gnt;
  assign rsp_in.bank  = rd_bank;

  fram_rsp_pipe #(
    .DEPTH   (RD_LAT),
    .stage_t (stage_t)
  ) u_rsp_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rsp_in),
    .q     (rsp_out)
  );

  assign rsp_valid = rsp_out.valid;
  assign rsp_data  = rsp_out.valid ? bram_rdata[rsp_out.bank] : '0;

endmodule

// File: tb/tb_fram_bank_arbiter.sv
// Directed bench: three arbiter configurations (linear/RD_LAT=1, interleaved, linear/RD_LAT=2)
// share one stimulus; bank models return {bank, bank_addr}.
module tb_fram_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_valid, wr_valid;
  logic [11:0] rd_addr, wr_addr;
  logic [15:0] wr_data;

  logic            a_rd_ready, a_wr_ready, a_rsp_valid;
  logic [15:0]     a_rsp_data, a_conflict_cnt;
  logic [3:0][9:0] a_bram_addr;
  logic [3:0][15:0] a_bram_wdata, a_m1;
  logic [3:0]      a_bram_we, a_bram_en;

  logic            b_rd_ready, b_wr_ready, b_rsp_valid;
  logic [15:0]     b_rsp_data, b_conflict_cnt;
  logic [3:0][9:0] b_bram_addr;
  logic [3:0][15:0] b_bram_wdata, b_m1;
  logic [3:0]      b_bram_we, b_bram_en;

  logic            c_rd_ready, c_wr_ready, c_rsp_valid;
  logic [15:0]     c_rsp_data, c_conflict_cnt;
  logic [3:0][9:0] c_bram_addr;
  logic [3:0][15:0] c_bram_wdata, c_m1, c_m2;
  logic [3:0]      c_bram_we, c_bram_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fram_bank_arbiter #(.NUM_BANKS(4), .ADDR_W(12), .DATA_W(16), .RD_LAT(1),
                      .INTERLEAVE(0), .STARVE_MAX(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(a_rd_ready), .rd_addr(rd_addr),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_addr(a_bram_addr), .bram_wdata(a_bram_wdata), .bram_we(a_bram_we),
    .bram_en(a_bram_en), .bram_rdata(a_m1), .conflict_cnt(a_conflict_cnt)
  );

  fram_bank_arbiter #(.NUM_BANKS(4), .ADDR_W(12), .DATA_W(16), .RD_LAT(1),
                      .INTERLEAVE(1), .STARVE_MAX(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(b_rd_ready), .rd_addr(rd_addr),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_addr(b_bram_addr), .bram_wdata(b_bram_wdata), .bram_we(b_bram_we),
    .bram_en(b_bram_en), .bram_rdata(b_m1), .conflict_cnt(b_conflict_cnt)
  );

  fram_bank_arbiter #(.NUM_BANKS(4), .ADDR_W(12), .DATA_W(16), .RD_LAT(2),
                      .INTERLEAVE(0), .STARVE_MAX(3)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(c_rd_ready), .rd_addr(rd_addr),
    .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data),
    .wr_valid(wr_valid), .wr_ready(c_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_addr(c_bram_addr), .bram_wdata(c_bram_wdata), .bram_we(c_bram_we),
    .bram_en(c_bram_en), .bram_rdata(c_m2), .conflict_cnt(c_conflict_cnt)
  );

  // Bank models: each word reads back as {bank, bank_addr}, RD_LAT register stages.
  for (genvar gi = 0; gi < 4; gi++) begin : g_model
    always @(posedge clk) begin
      a_m1[gi] <= {4'h0, 2'(gi), a_bram_addr[gi]};
      b_m1[gi] <= {4'h0, 2'(gi), b_bram_addr[gi]};
      c_m1[gi] <= {4'h0, 2'(gi), c_bram_addr[gi]};
      c_m2[gi] <= c_m1[gi];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n    = 1'b0;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [4:0] exp_rd;
  logic [4:0] exp_wr;

  initial begin
    rst_n = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    exp_rd = 5'b01000;
    exp_wr = 5'b10111;

    // Reset forces handshakes and bank enables low even with requests pending
    rd_valid = 1'b1; wr_valid = 1'b1; rd_addr = 12'h400; wr_addr = 12'h400;
    #1;
    check("rst_rd_ready", a_rd_ready, 1'b0);
    check("rst_wr_ready", a_wr_ready, 1'b0);
    check("rst_en", a_bram_en, 4'b0000);
    tick();
    tick();
    check("rst_conflict_cnt", a_conflict_cnt, 16'd0);
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    $display("reset: en=%b cnt=%0d", a_bram_en, a_conflict_cnt);

    // Parallel read bank 1 / write bank 2
    reset_all();
    rd_valid = 1'b1; rd_addr = 12'h400;
    wr_valid = 1'b1; wr_addr = 12'h800; wr_data = 16'hBEEF;
    #1;
    check("par_rd_ready", a_rd_ready, 1'b1);
    check("par_wr_ready", a_wr_ready, 1'b1);
    check("par_en", a_bram_en, 4'b0110);
    check("par_we", a_bram_we, 4'b0100);
    check("par_waddr", a_bram_addr[2], 10'h000);
    check("par_wdata", a_bram_wdata[2], 16'hBEEF);
    tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    check("par_rsp_valid", a_rsp_valid, 1'b1);
    check("par_rsp_data", a_rsp_data, 16'h0400);
    $display("parallel: rsp_data=%h", a_rsp_data);

    // Same-bank conflict with starvation guard
    reset_all();
    rd_valid = 1'b1; rd_addr = 12'h010;
    wr_valid = 1'b1; wr_addr = 12'h020; wr_data = 16'h5A5A;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("cfl_rd_ready_%0d", k), a_rd_ready, exp_rd[k]);
      check($sformatf("cfl_wr_ready_%0d", k), a_wr_ready, exp_wr[k]);
      if (k == 0) begin
        check("cfl_waddr", a_bram_addr[0], 10'h020);
        check("cfl_wdata", a_bram_wdata[0], 16'h5A5A);
      end
      if (k == 3) begin
        check("cfl_rd_en", a_bram_en, 4'b0001);
        check("cfl_rd_we", a_bram_we, 4'b0000);
        check("cfl_raddr", a_bram_addr[0], 10'h010);
      end
      if (k == 4) begin
        check("cfl_rsp_valid", a_rsp_valid, 1'b1);
        check("cfl_rsp_data", a_rsp_data, 16'h0010);
      end else begin
        check($sformatf("cfl_rsp_idle_%0d", k), a_rsp_valid, 1'b0);
      end
      $display("conflict cycle %0d: rd_ready=%b wr_ready=%b", k, a_rd_ready, a_wr_ready);
      tick();
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    check("cfl_count", a_conflict_cnt, 16'd5);

    // Interleaved layout: 0x005 -> bank 1, 0x006 -> bank 2
    reset_all();
    rd_valid = 1'b1; rd_addr = 12'h005;
    wr_valid = 1'b1; wr_addr = 12'h006; wr_data = 16'h1234;
    #1;
    check("ilv_rd_ready", b_rd_ready, 1'b1);
    check("ilv_wr_ready", b_wr_ready, 1'b1);
    check("ilv_en", b_bram_en, 4'b0110);
    check("ilv_we", b_bram_we, 4'b0100);
    check("ilv_raddr", b_bram_addr[1], 10'h001);
    check("ilv_waddr", b_bram_addr[2], 10'h001);
    check("ilv_wdata", b_bram_wdata[2], 16'h1234);
    tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    check("ilv_rsp_valid", b_rsp_valid, 1'b1);
    check("ilv_rsp_data", b_rsp_data, 16'h0401);
    check("ilv_conflict_cnt", b_conflict_cnt, 16'd0);
    $display("interleave: rsp_data=%h", b_rsp_data);

    // Streaming reads through the RD_LAT=2 instance
    reset_all();
    for (int i = 0; i < 19; i++) begin
      rd_valid = (i < 16);
      rd_addr  = 12'(i);
      #1;
      if (i < 16) begin
        check($sformatf("str_rd_ready_%0d", i), c_rd_ready, 1'b1);
        check($sformatf("str_wr_ready_%0d", i), c_wr_ready, 1'b0);
        check($sformatf("str_wdata_%0d", i), c_bram_wdata[0], 16'h0000);
      end
      if (i >= 2 && i < 18) begin
        check($sformatf("str_rsp_valid_%0d", i), c_rsp_valid, 1'b1);
        check($sformatf("str_rsp_data_%0d", i), c_rsp_data, 16'(i - 2));
        $display("stream rsp %0d: data=%h", i - 2, c_rsp_data);
      end else begin
        check($sformatf("str_rsp_idle_%0d", i), c_rsp_valid, 1'b0);
      end
      tick();
    end

    // Reset while a read is in flight in the RD_LAT=2 instance
    reset_all();
    rd_valid = 1'b1; rd_addr = 12'h400;
    #1;
    check("mid_rd_accept", c_rd_ready, 1'b1);
    tick();
    rst_n = 1'b0;
    wr_valid = 1'b1; wr_addr = 12'h400;
    #1;
    check("mid_rd_ready", c_rd_ready, 1'b0);
    check("mid_wr_ready", c_wr_ready, 1'b0);
    check("mid_en", c_bram_en, 4'b0000);
    check("mid_we", c_bram_we, 4'b0000);
    tick();
    check("mid_rsp_valid", c_rsp_valid, 1'b0);
    check("mid_conflict_cnt", c_conflict_cnt, 16'd0);
    rst_n = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
    tick();
    check("mid_rsp_after", c_rsp_valid, 1'b0);
    $display("reset mid-flight: rsp_valid=%b", c_rsp_valid);

    // Conflict counter saturation
    reset_all();
    rd_valid = 1'b1; rd_addr = 12'h010;
    wr_valid = 1'b1; wr_addr = 12'h020;
    repeat (65534) tick();
    check("sat_fffe", a_conflict_cnt, 16'hFFFE);
    tick();
    check("sat_ffff", a_conflict_cnt, 16'hFFFF);
    repeat (5) tick();
    check("sat_hold", a_conflict_cnt, 16'hFFFF);
    $display("saturation: conflict_cnt=%h", a_conflict_cnt);
    rd_valid = 1'b0; wr_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fram_bank_arbiter.md
Name: fram_bank_arbiter

Overview:
- Parametrised, registered successor to the single-cycle feature-RAM bank mux.
- Connects one read requester and one write requester (valid/ready) to NUM_BANKS single-port BRAM banks.
- Selects the bank by high-order or interleaved low-order address bits.
- Arbitrates same-bank conflicts with a starvation guard, aligns read data to the BRAM latency and counts conflicts.
- Sits between the CU/writeback datapath and the FRAM bank array.

Parameters:
- NUM_BANKS, 4, bank count; power of two, ≥2.
- ADDR_W, 12, global word address width.
- DATA_W, 16, word width.
- RD_LAT, 1, BRAM read latency in cycles; ≥1.
- INTERLEAVE, 0, 0 = bank from address MSBs, 1 = bank from address LSBs.
- STARVE_MAX, 3, consecutive lost read arbitrations before the read is forced to win; ≥1.
- BANK_AW (derived), ADDR_W - log2(NUM_BANKS), per-bank address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  ADDR_W  read address
- rsp_valid  out  1  read data valid
- rsp_data  out  DATA_W  read data
- wr_valid  in  1  write request valid
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- bram_addr  out  [NUM_BANKS] x BANK_AW  per-bank address
- bram_wdata  out  [NUM_BANKS] x DATA_W  per-bank write data
- bram_we  out  NUM_BANKS  per-bank write enable
- bram_en  out  NUM_BANKS  per-bank enable
- bram_rdata  in  [NUM_BANKS] x DATA_W  per-bank read data
- conflict_cnt  out  16  saturating count of conflict cycles

Behaviour:
- Address split:
  - INTERLEAVE=0: bank = addr[ADDR_W-1 -: log2(NUM_BANKS)], bank address = low BANK_AW bits.
  - INTERLEAVE=1: bank = addr[log2(NUM_BANKS)-1:0], bank address = high BANK_AW bits.
- Grant logic (combinational from the current inputs and the starvation counter):
  - Different banks, or only one requester valid: every valid requester is granted.
  - Conflict (both valid, same bank): write wins; the read wins only when starve_cnt == STARVE_MAX.
- Handshake:
  - rd_ready = read grant; wr_ready = write grant.
  - A transfer occurs on valid&ready.
  - Requesters hold addr/data stable while valid&!ready.
  - ready is never asserted without valid.
- Bank drive:
  - Granted write: en=1, we=1, addr and wdata from the write port.
  - Granted read: en=1, we=0, wdata=0.
  - Idle banks: en=0, we=0, addr=0, wdata=0.
- starve_cnt (register, width clog2(STARVE_MAX+1)):
  - Increments on each conflict cycle the read loses.
  - Clears on any read grant, or on a cycle with rd_valid=0.
- Read return pipeline: RD_LAT stages carrying {valid, bank index}.
  - Stage 0 loads {rd_valid&rd_ready, read bank}.
  - rsp_valid = last-stage valid.
  - rsp_data = bram_rdata[last-stage bank] when valid, else 0.
  - Latency: accept at cycle t → rsp_valid at t+RD_LAT.
  - Back-to-back reads give one response per cycle, in order.
  - No back-pressure on responses; the consumer must accept them.
- conflict_cnt increments on every conflict cycle and saturates at 16'hFFFF.
- Reset (rst_n=0 sampled at a clk edge):
  - Pipeline valids, starve_cnt and conflict_cnt clear.
  - While rst_n=0, rd_ready, wr_ready, all bram_en and bram_we are forced to 0.
  - Reset mid-operation discards in-flight responses; no rsp_valid for reads accepted before reset.
- Same-address read and write in one cycle are always a conflict. Write-first ordering applies unless starvation forces the read.

Decomposition:
- Shared package fram_pkg:
  - bank-select function (addr, INTERLEAVE) → {bank, bank_addr}
  - typedef of response pipeline stage {logic valid; logic [log2 NB-1:0] bank;}
  - default parameter constants.
- One sub-module, fram_rsp_pipe: RD_LAT-deep valid/bank shift register with synchronous reset.
- Arbitration and bank drive stay in the top level.

Test Plan (NUM_BANKS=4, ADDR_W=12, DATA_W=16, RD_LAT=1, STARVE_MAX=3, bank models return {bank, addr[9:0]}):
- Parallel access: INTERLEAVE=0, read 0x400 and write 0x800 valid together → both ready; bram_en=4'b0110, we=4'b0100; rsp_valid next cycle with bank-1 data of address 0x000.
- Conflict and starvation: read 0x010 and write 0x020 held valid for 5 cycles → wr_ready on cycles 0–2, rd_ready only on cycle 3, write again on cycle 4; conflict_cnt=5.
- Interleave: INTERLEAVE=1, read 0x005 → bank 1, bram_addr[1]=0x001. Write 0x006 → bank 2, same cycle, no conflict.
- Streaming reads: RD_LAT=2, reads at addresses 0x000..0x00F on consecutive cycles → 16 responses, in order, each 2 cycles after accept, no gaps.
- Reset mid-flight: accept a read, assert rst_n=0 next edge → rsp_valid stays 0, conflict_cnt=0, all en/we=0 during reset.
- Counter saturation: force 65540 conflict cycles → conflict_cnt holds 16'hFFFF.
